// File: rtl/l2_pkg.sv
`default_nettype none
// l2_pkg: shared geometry, requester IDs and FSM state type for the L2 data array controller.
// Rev 1.0
package l2_pkg;
    localparam int ADDR_WIDTH = 7;
    localparam int DATA_WIDTH = 1024;
    localparam int NUM_WMASKS = DATA_WIDTH / 8;
    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

    localparam logic RD_ID_L1_MISS = 1'b0;
    localparam logic RD_ID_EVICT   = 1'b1;
    localparam logic WR_ID_FILL    = 1'b0;
    localparam logic WR_ID_WB      = 1'b1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;
endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// rr_arb2: two-way round-robin arbiter; priority passes to the other requester after each grant.
// Rev 1.0
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       sel_vld_o,
    output logic       sel_id_o,
    output logic [1:0] gnt_o
);
    logic prio_q;

    // Selection is visible even when the grant is suppressed, so the caller can run hazard checks on it.
    assign sel_vld_o = |req_i;
    assign sel_id_o  = req_i[prio_q] ? prio_q : ~prio_q;
    assign gnt_o     = (sel_vld_o && en_i) ? (sel_id_o ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (sel_vld_o && en_i) begin
            prio_q <= ~sel_id_o;
        end
    end
endmodule
`default_nettype wire

// File: rtl/l2_array_ctrl.sv
`default_nettype none
// l2_array_ctrl: zero-initialises the L2 data array, then arbitrates two readers and two writers onto a 1R1W macro.
// Rev 1.0
module l2_array_ctrl #(
    parameter int ADDR_WIDTH = l2_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = l2_pkg::DATA_WIDTH,
    parameter int NUM_WMASKS = l2_pkg::NUM_WMASKS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              rd_req_valid,
    output logic [1:0]              rd_req_ready,
    input  logic [2*ADDR_WIDTH-1:0] rd_req_addr,
    input  logic [1:0]              wr_req_valid,
    output logic [1:0]              wr_req_ready,
    input  logic [2*ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [2*NUM_WMASKS-1:0] wr_req_wmask,
    input  logic [2*DATA_WIDTH-1:0] wr_req_data,
    output logic                    rd_rsp_valid,
    output logic                    rd_rsp_id,
    output logic [DATA_WIDTH-1:0]   rd_rsp_data,
    output logic                    init_done,
    output logic                    sram_csb0,
    output logic [ADDR_WIDTH-1:0]   sram_addr0,
    output logic [NUM_WMASKS-1:0]   sram_wmask0,
    output logic [DATA_WIDTH-1:0]   sram_din0,
    output logic                    sram_csb1,
    output logic [ADDR_WIDTH-1:0]   sram_addr1,
    input  logic [DATA_WIDTH-1:0]   sram_dout1
);
    import l2_pkg::state_e, l2_pkg::ST_INIT, l2_pkg::ST_RUN, l2_pkg::RD_ID_L1_MISS;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic                  init_done_q;
    logic                  rsp_valid_q;
    logic                  rsp_id_q;

    logic                  w_run;
    logic                  w_wr_vld, w_wr_sel, w_rd_vld, w_rd_sel;
    logic [1:0]            w_wr_gnt, w_rd_gnt;
    logic [ADDR_WIDTH-1:0] w_wr_addr, w_rd_addr;
    logic [NUM_WMASKS-1:0] w_wr_wmask;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_hazard;

    assign w_run = (state_q == ST_RUN);

    assign w_wr_addr  = w_wr_sel ? wr_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : wr_req_addr[ADDR_WIDTH-1:0];
    assign w_wr_wmask = w_wr_sel ? wr_req_wmask[2*NUM_WMASKS-1:NUM_WMASKS] : wr_req_wmask[NUM_WMASKS-1:0];
    assign w_wr_data  = w_wr_sel ? wr_req_data[2*DATA_WIDTH-1:DATA_WIDTH]  : wr_req_data[DATA_WIDTH-1:0];
    assign w_rd_addr  = w_rd_sel ? rd_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : rd_req_addr[ADDR_WIDTH-1:0];

    // Same-line collision: the write wins so the stalled read later observes the new data.
    assign w_hazard = w_wr_vld && w_rd_vld && (w_wr_addr == w_rd_addr);

    rr_arb2 u_wr_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (wr_req_valid),
        .en_i      (w_run),
        .sel_vld_o (w_wr_vld),
        .sel_id_o  (w_wr_sel),
        .gnt_o     (w_wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (rd_req_valid),
        .en_i      (w_run && !w_hazard),
        .sel_vld_o (w_rd_vld),
        .sel_id_o  (w_rd_sel),
        .gnt_o     (w_rd_gnt)
    );

    assign rd_req_ready = w_rd_gnt;
    assign wr_req_ready = w_wr_gnt;
    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_id    = rsp_id_q;
    assign rd_rsp_data  = sram_dout1;
    assign init_done    = init_done_q;

    // The rst term keeps the macro deselected while reset is held, not just from the next edge.
    always_comb begin
        sram_csb0   = 1'b1;
        sram_addr0  = '0;
        sram_wmask0 = '0;
        sram_din0   = '0;
        sram_csb1   = 1'b1;
        sram_addr1  = '0;
        if (state_q == ST_INIT && !rst) begin
            sram_csb0   = 1'b0;
            sram_addr0  = init_cnt_q;
            sram_wmask0 = '1;
        end else if (|w_wr_gnt) begin
            sram_csb0   = 1'b0;
            sram_addr0  = w_wr_addr;
            sram_wmask0 = w_wr_wmask;
            sram_din0   = w_wr_data;
        end
        if (|w_rd_gnt) begin
            sram_csb1  = 1'b0;
            sram_addr1 = w_rd_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= RD_ID_L1_MISS;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (&init_cnt_q) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
            rsp_valid_q <= |w_rd_gnt;
            rsp_id_q    <= w_rd_sel;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_l2_array_ctrl.sv
`default_nettype none
// tb_l2_array_ctrl: directed and randomised checks of l2_array_ctrl against a transaction-level model.
// Rev 1.0
module tb_l2_array_ctrl;
    localparam int AW    = 7;
    localparam int DW    = 1024;
    localparam int NW    = 128;
    localparam int DEPTH = 128;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      rd_req_valid, rd_req_ready, wr_req_valid, wr_req_ready;
    logic [2*AW-1:0] rd_req_addr, wr_req_addr;
    logic [2*NW-1:0] wr_req_wmask;
    logic [2*DW-1:0] wr_req_data;
    logic            rd_rsp_valid, rd_rsp_id, init_done;
    logic [DW-1:0]   rd_rsp_data;
    logic            sram_csb0, sram_csb1;
    logic [AW-1:0]   sram_addr0, sram_addr1;
    logic [NW-1:0]   sram_wmask0;
    logic [DW-1:0]   sram_din0, sram_dout1;

    logic [DW-1:0]   mem     [DEPTH];
    logic [DW-1:0]   ref_mem [DEPTH];
    int              n_checks = 0;
    int              n_pass   = 0;
    int              rd_fav, wr_fav;

    always #5 clk = ~clk;

    l2_array_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_req_addr  (wr_req_addr),
        .wr_req_wmask (wr_req_wmask),
        .wr_req_data  (wr_req_data),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_id    (rd_rsp_id),
        .rd_rsp_data  (rd_rsp_data),
        .init_done    (init_done),
        .sram_csb0    (sram_csb0),
        .sram_addr0   (sram_addr0),
        .sram_wmask0  (sram_wmask0),
        .sram_din0    (sram_din0),
        .sram_csb1    (sram_csb1),
        .sram_addr1   (sram_addr1),
        .sram_dout1   (sram_dout1)
    );

    // 1R1W macro with registered read data
    always @(posedge clk) begin
        if (!sram_csb0)
            for (int b = 0; b < NW; b++)
                if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end

    function automatic logic [DW-1:0] rnd_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [NW-1:0] rnd_mask();
        logic [NW-1:0] v;
        for (int i = 0; i < NW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [NW-1:0] m);
        logic [DW-1:0] r = old;
        for (int b = 0; b < NW; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        rd_req_valid = 2'b00; rd_req_addr  = '0;
        wr_req_valid = 2'b00; wr_req_addr  = '0;
        wr_req_wmask = '0;    wr_req_data  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        rd_req_valid = 2'b11;
        wr_req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({sram_csb0, sram_csb1} !== 2'b11) $display("FAIL reset_csb: got %b exp 11", {sram_csb0, sram_csb1}); else n_pass++;
        n_checks++; if ({rd_req_ready, wr_req_ready} !== 4'b0) $display("FAIL reset_ready: got %b exp 0000", {rd_req_ready, wr_req_ready}); else n_pass++;
        n_checks++; if ({rd_rsp_valid, init_done} !== 2'b00) $display("FAIL reset_rsp_done: got %b exp 00", {rd_rsp_valid, init_done}); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_init();
        int bad = 0;
        rd_req_valid = 2'b11; rd_req_addr = {7'd9, 7'd5};
        wr_req_valid = 2'b11; wr_req_addr = {7'd1, 7'd2};
        wr_req_wmask = '1;    wr_req_data = {2{rnd_line()}};
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if ({sram_csb0, sram_addr0, sram_csb1, rd_req_ready, wr_req_ready, init_done} !== {1'b0, AW'(i), 1'b1, 5'b0}
                || sram_wmask0 !== {NW{1'b1}} || sram_din0 !== '0) begin
                if (bad < 4) $display("FAIL init_write[%0d]: got csb0=%b addr=%0d csb1=%b rdy=%b/%b done=%b exp csb0=0 addr=%0d csb1=1 rdy=0 done=0",
                                      i, sram_csb0, sram_addr0, sram_csb1, rd_req_ready, wr_req_ready, init_done, i);
                bad++;
            end
            if (i == DEPTH-1) idle_inputs();
            @(posedge clk);
        end
        n_checks++; if (bad !== 0) $display("FAIL init_sequence: got %0d bad cycles exp 0", bad); else n_pass++;
        #1;
        n_checks++; if (init_done !== 1'b1) $display("FAIL init_done_cycle129: got %b exp 1", init_done); else n_pass++;
        n_checks++; if ({sram_csb0, sram_csb1} !== 2'b11) $display("FAIL run_idle_csb: got %b exp 11", {sram_csb0, sram_csb1}); else n_pass++;
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        rd_fav = 0; wr_fav = 0;
    endtask

    task automatic test_rr_reads();
        int exp_id [4] = '{0, 1, 0, 1};
        rd_req_valid = 2'b11; rd_req_addr = {7'd9, 7'd5};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (rd_req_ready !== 2'(1 << exp_id[k]) || sram_csb1 !== 1'b0 || sram_addr1 !== (exp_id[k] ? 7'd9 : 7'd5))
                $display("FAIL rr_grant[%0d]: got rdy=%b csb1=%b addr1=%0d exp rdy=%b addr1=%0d", k, rd_req_ready, sram_csb1, sram_addr1,
                         2'(1 << exp_id[k]), exp_id[k] ? 9 : 5);
            else n_pass++;
            if (k > 0) begin
                n_checks++; if ({rd_rsp_valid, rd_rsp_id} !== {1'b1, 1'(exp_id[k-1])} || rd_rsp_data !== '0)
                    $display("FAIL rr_rsp[%0d]: got v=%b id=%b exp v=1 id=%0d", k, rd_rsp_valid, rd_rsp_id, exp_id[k-1]);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        n_checks++; if ({rd_rsp_valid, rd_rsp_id} !== 2'b11) $display("FAIL rr_rsp_last: got %b exp 11", {rd_rsp_valid, rd_rsp_id}); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (rd_rsp_valid !== 1'b0) $display("FAIL rr_rsp_drop: got %b exp 0", rd_rsp_valid); else n_pass++;
        rd_fav = 0;
    endtask

    task automatic test_raw();
        logic [DW-1:0] exp_line = '0;
        exp_line[7:0] = 8'hA5;
        wr_req_valid = 2'b01; wr_req_addr = {7'd0, 7'd3};
        wr_req_wmask = {{NW{1'b0}}, {(NW-1){1'b0}}, 1'b1};
        wr_req_data  = {rnd_line(), {(DW-8){1'b1}}, 8'hA5};
        @(negedge clk);
        n_checks++; if (wr_req_ready !== 2'b01 || sram_csb0 !== 1'b0 || sram_addr0 !== 7'd3 || sram_wmask0 !== NW'(1))
            $display("FAIL raw_write: got rdy=%b csb0=%b addr0=%0d exp rdy=01 csb0=0 addr0=3", wr_req_ready, sram_csb0, sram_addr0);
        else n_pass++;
        ref_mem[3] = merge(ref_mem[3], wr_req_data[DW-1:0], wr_req_wmask[NW-1:0]);
        @(posedge clk); #1;
        idle_inputs();
        rd_req_valid = 2'b01; rd_req_addr = {7'd0, 7'd3};
        @(negedge clk);
        n_checks++; if (rd_req_ready !== 2'b01) $display("FAIL raw_read_ready: got %b exp 01", rd_req_ready); else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        n_checks++; if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== exp_line || rd_rsp_data !== ref_mem[3])
            $display("FAIL raw_data: got v=%b data=%h exp %h", rd_rsp_valid, rd_rsp_data, exp_line);
        else n_pass++;
        rd_fav = 1; wr_fav = 1;
    endtask

    task automatic test_hazard();
        logic [DW-1:0] d = rnd_line();
        wr_req_valid = 2'b01; wr_req_addr = {7'd0, 7'd7}; wr_req_wmask = {{NW{1'b0}}, {NW{1'b1}}}; wr_req_data = {{DW{1'b0}}, d};
        rd_req_valid = 2'b01; rd_req_addr = {7'd0, 7'd7};
        @(negedge clk);
        n_checks++; if ({wr_req_ready, rd_req_ready, sram_csb1} !== 5'b01_00_1)
            $display("FAIL hazard_stall: got wr=%b rd=%b csb1=%b exp wr=01 rd=00 csb1=1", wr_req_ready, rd_req_ready, sram_csb1);
        else n_pass++;
        ref_mem[7] = d;
        @(posedge clk); #1;
        wr_req_valid = 2'b00;
        @(negedge clk);
        n_checks++; if (rd_req_ready !== 2'b01) $display("FAIL hazard_retry: got %b exp 01", rd_req_ready); else n_pass++;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        n_checks++; if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== ref_mem[7])
            $display("FAIL hazard_data: got v=%b data=%h exp %h", rd_rsp_valid, rd_rsp_data, ref_mem[7]);
        else n_pass++;
        rd_fav = 1; wr_fav = 1;
    endtask

    task automatic test_random();
        int            bad = 0;
        int            wp, rp;
        logic          pend_v = 1'b0;
        logic          pend_id = 1'b0;
        logic [DW-1:0] pend_d = '0;
        logic [1:0]    exp_wr, exp_rd;
        logic [AW-1:0] wa, ra;
        for (int c = 0; c < 400; c++) begin
            rd_req_valid = 2'($urandom);
            wr_req_valid = 2'($urandom);
            rd_req_addr  = {7'($urandom_range(0, 3)), 7'($urandom_range(0, 3))};
            wr_req_addr  = {7'($urandom_range(0, 3)), 7'($urandom_range(0, 3))};
            wr_req_wmask = ($urandom_range(0, 3) == 0) ? '1 : {rnd_mask(), rnd_mask()};
            wr_req_data  = {rnd_line(), rnd_line()};
            @(negedge clk);
            wp = (wr_req_valid == 2'b11) ? wr_fav : (wr_req_valid == 2'b01) ? 0 : (wr_req_valid == 2'b10) ? 1 : -1;
            rp = (rd_req_valid == 2'b11) ? rd_fav : (rd_req_valid == 2'b01) ? 0 : (rd_req_valid == 2'b10) ? 1 : -1;
            wa = (wp >= 0) ? wr_req_addr[wp*AW +: AW] : '0;
            ra = (rp >= 0) ? rd_req_addr[rp*AW +: AW] : '0;
            if (wp >= 0 && rp >= 0 && wa == ra) rp = -1;
            exp_wr = (wp >= 0) ? 2'(1 << wp) : 2'b00;
            exp_rd = (rp >= 0) ? 2'(1 << rp) : 2'b00;
            if (wr_req_ready !== exp_wr || rd_req_ready !== exp_rd || rd_rsp_valid !== pend_v
                || (pend_v && (rd_rsp_id !== pend_id || rd_rsp_data !== pend_d))) begin
                if (bad < 4) $display("FAIL rand_cycle[%0d]: got wr=%b rd=%b rv=%b id=%b exp wr=%b rd=%b rv=%b id=%b data_ok=%b",
                                      c, wr_req_ready, rd_req_ready, rd_rsp_valid, rd_rsp_id, exp_wr, exp_rd, pend_v, pend_id,
                                      rd_rsp_data === pend_d);
                bad++;
            end
            pend_v = (rp >= 0);
            if (rp >= 0) begin
                pend_id = 1'(rp);
                pend_d  = ref_mem[ra];
                rd_fav  = 1 - rp;
            end
            if (wp >= 0) begin
                ref_mem[wa] = merge(ref_mem[wa], wr_req_data[wp*DW +: DW], wr_req_wmask[wp*NW +: NW]);
                wr_fav = 1 - wp;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        if (rd_rsp_valid !== pend_v || (pend_v && (rd_rsp_id !== pend_id || rd_rsp_data !== pend_d))) bad++;
        n_checks++; if (bad !== 0) $display("FAIL random_traffic: got %0d bad cycles exp 0", bad); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        @(posedge clk); #1;
        rd_req_valid = 2'b01; rd_req_addr = {7'd0, 7'd1};
        @(posedge clk); #1;
        idle_inputs();
        n_checks++; if (rd_rsp_valid !== 1'b1) $display("FAIL midrun_pending: got %b exp 1", rd_rsp_valid); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if ({rd_rsp_valid, init_done, sram_csb0, sram_csb1} !== 4'b0011)
            $display("FAIL midrun_reset: got rv/done/csb0/csb1=%b exp 0011", {rd_rsp_valid, init_done, sram_csb0, sram_csb1});
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_init();
        int cnt = 0;
        @(negedge clk);
        n_checks++; if ({sram_csb0, sram_addr0} !== {1'b0, 7'd0}) $display("FAIL reinit_start: got csb0=%b addr=%0d exp 0/0", sram_csb0, sram_addr0); else n_pass++;
        repeat (60) @(posedge clk);
        #1;
        n_checks++; if ({sram_csb0, sram_addr0} !== {1'b0, 7'd60}) $display("FAIL init_at60: got csb0=%b addr=%0d exp 0/60", sram_csb0, sram_addr0); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if ({sram_csb0, sram_csb1} !== 2'b11) $display("FAIL init60_reset_csb: got %b exp 11", {sram_csb0, sram_csb1}); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++; if ({sram_csb0, sram_addr0} !== {1'b0, 7'd0}) $display("FAIL init_restart: got csb0=%b addr=%0d exp 0/0", sram_csb0, sram_addr0); else n_pass++;
        while (!init_done && cnt < 300) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_checks++; if (cnt !== DEPTH) $display("FAIL reinit_length: got %0d cycles exp %0d", cnt, DEPTH); else n_pass++;
        rd_req_valid = 2'b11; rd_req_addr = {7'd9, 7'd5};
        #1;
        n_checks++; if (rd_req_ready !== 2'b01) $display("FAIL rr_ptr_reset: got %b exp 01", rd_req_ready); else n_pass++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_init();
        test_rr_reads();
        test_raw();
        test_hazard();
        test_random();
        test_reset_mid_run();
        test_reset_mid_init();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
